dff_sync: RTL and testbench
===========================

DFF_SYNC -- requirements
Module: dff_sync

Interface
REQ-001 Parameter: WIDTH, default 1, data path width in bits; all data ports and the state register SHALL be WIDTH bits.
REQ-002 Port order SHALL be exactly CK, D, LD, Q, QB, RB, SB for positional instantiation; the port lines below are listed clock/reset first.
REQ-003 CK  input  1  the single clock; all synchronous behaviour is on the rising edge.
REQ-004 RB  input  1  reset; asynchronous, active-low.
REQ-005 SB  input  1  set; active-low, synchronous to CK.
REQ-006 LD  input  1  load enable, active-high.
REQ-007 D  input  WIDTH  data to be loaded.
REQ-008 Q  output  WIDTH  stored value.
REQ-009 QB  output  WIDTH  bitwise complement of Q.

Function
REQ-010 RB=0 SHALL force Q to all-zeros immediately, independent of CK, and hold it there while RB=0.
REQ-011 On a rising CK edge with RB=1 and SB=0, Q SHALL become all-ones.
REQ-012 On a rising CK edge with RB=1, SB=1 and LD=1, Q SHALL become D.
REQ-013 On a rising CK edge with RB=1, SB=1 and LD=0, Q SHALL hold its value.
REQ-014 Priority SHALL be RB (async) over SB over LD; SB=0 with LD=1 sets, ignoring D.
REQ-015 Latency: a load or set SHALL be visible on Q at the rising CK edge that samples it; the delay is zero cycles after that edge and one edge after the input change.
REQ-016 QB SHALL be combinational ~Q at all times, including during reset and while Q is unknown.
REQ-017 Deassertion of RB SHALL NOT change Q; Q stays zero until the next qualifying rising edge.
REQ-018 RB asserted coincident with a rising edge SHALL win; Q is zero after that edge.
REQ-019 The block has no state machine and no handshake; it is a single register.

Reset
REQ-020 Reset value: Q = all-zeros, QB = all-ones.
REQ-021 Before the first RB assertion or SB set, Q is unknown; verification SHALL NOT check Q until after the first reset or set.
REQ-022 SB is not a reset; it is sampled only on CK.

Structure
REQ-023 The block SHALL be a single module with one sequential process, sensitive to the CK rising edge and the RB falling edge, plus a continuous QB assignment.
REQ-024 No shared package is required; WIDTH is a module parameter.
REQ-025 No sub-module; the block is the leaf.

Verification (clock period 100, first rising edge at t=50, WIDTH=1)
REQ-026 Set: SB=0 at t=125, RB=1 -> edge t=150 gives Q=1, QB=0; SB=1 at t=225 -> Q stays 1.
REQ-027 Async reset: RB=0 at t=325, mid-cycle -> Q=0, QB=1 at t=325, before any edge; RB=1 at t=425 -> Q stays 0 through edge t=450 with LD=0.
REQ-028 Load: LD=1, D=1 at t=525 -> edge t=550 gives Q=1; LD=0 at t=625 -> Q holds 1 through edges t=650 and t=750.
REQ-029 Priority: SB=0, LD=1, D=0 at an edge -> Q=1; RB=0 together with SB=0 -> Q=0.
REQ-030 Hold: LD=0, SB=1, with D toggled every half cycle for 4 cycles -> Q unchanged.
REQ-031 Every check SHALL also confirm QB == ~Q.

Source files
------------

// File: rtl/dff_sync_pkg.sv
// Shared constants for the dff_sync register.
`timescale 1ns/1ps
package dff_sync_pkg;

    // Data path width used when an instance does not override WIDTH.
    localparam int unsigned DEFAULT_WIDTH = 1;

endpackage : dff_sync_pkg

// File: rtl/dff_sync.sv
// Single WIDTH-bit register with asynchronous active-low reset (RB),
// synchronous active-low set (SB) and active-high load enable (LD).
// QB is the combinational complement of Q.
`timescale 1ns/1ps
module dff_sync
    import dff_sync_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CK,
    input  logic [WIDTH-1:0] D,
    input  logic             LD,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QB,
    input  logic             RB,
    input  logic             SB
);

    // State register: reset dominates set, set dominates load, otherwise hold.
    always_ff @(posedge CK or negedge RB) begin
        if (!RB) begin
            Q <= '0;
        end else if (!SB) begin
            Q <= '1;
        end else if (LD) begin
            Q <= D;
        end
    end

    // Complement output follows Q at all times, including reset and X.
    assign QB = ~Q;

endmodule : dff_sync

// File: tb/tb_dff_sync.sv
// Scoreboard bench for dff_sync: directed sequence followed by random
// traffic, checked against a behavioural model on a 1-bit and an 8-bit
// instance that share clock and control.
`timescale 1ns/1ps
module tb_dff_sync;

    logic       CK;
    logic       RB;
    logic       SB;
    logic       LD;
    logic       D1;
    logic [7:0] D8;
    logic       Q1;
    logic       QB1;
    logic [7:0] Q8;
    logic [7:0] QB8;

    dff_sync #(.WIDTH(1)) u_dut1 (
        .CK (CK),
        .D  (D1),
        .LD (LD),
        .Q  (Q1),
        .QB (QB1),
        .RB (RB),
        .SB (SB)
    );

    dff_sync #(.WIDTH(8)) u_dut8 (
        .CK (CK),
        .D  (D8),
        .LD (LD),
        .Q  (Q8),
        .QB (QB8),
        .RB (RB),
        .SB (SB)
    );

    typedef struct {
        logic       valid;
        logic       q1;
        logic [7:0] q8;
        string      tag;
    } exp_t;

    exp_t edge_q[$];
    exp_t async_q[$];
    event async_ev;

    int errors = 0;
    int checks = 0;

    // Reference state: value the register must hold, and whether it is known yet.
    logic       m_valid = 1'b0;
    logic       m_q1;
    logic [7:0] m_q8;
    logic       prev_rb = 1'b1;

    // First rising edge at t=50, period 100.
    initial begin
        CK = 1'b0;
        forever #50 CK = ~CK;
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic compare(input exp_t e);
        if (e.valid) begin
            chk({e.tag, " Q1"},  {7'd0, Q1},  {7'd0, e.q1});
            chk({e.tag, " QB1"}, {7'd0, QB1}, {7'd0, ~e.q1});
            chk({e.tag, " Q8"},  Q8,  e.q8);
            chk({e.tag, " QB8"}, QB8, ~e.q8);
        end
    endtask

    // Edge monitor: one expectation per rising edge, sampled 1 ns later.
    initial begin
        exp_t e;
        forever begin
            @(posedge CK);
            #1;
            if (edge_q.size() == 0) begin
                chk("edge queue underrun", 8'd0, 8'd1);
            end else begin
                e = edge_q.pop_front();
                compare(e);
            end
        end
    end

    // Asynchronous monitor: checks Q between edges after RB changes.
    initial begin
        exp_t e;
        forever begin
            @(async_ev);
            #1;
            while (async_q.size() != 0) begin
                e = async_q.pop_front();
                compare(e);
            end
        end
    end

    function automatic exp_t snap(input string tag);
        exp_t e;
        e.valid = m_valid;
        e.q1    = m_q1;
        e.q8    = m_q8;
        e.tag   = tag;
        return e;
    endfunction

    // Apply inputs at x25 (mid low-to-high half), update the model and queue
    // the expectation for the edge at x50.
    task automatic step(input string tag, input logic rb, input logic sb,
                        input logic ld, input logic d1, input logic [7:0] d8);
        @(negedge CK);
        #25;
        RB = rb;
        SB = sb;
        LD = ld;
        D1 = d1;
        D8 = d8;
        if (!rb) begin
            m_q1    = 1'b0;
            m_q8    = 8'h00;
            m_valid = 1'b1;
        end
        if (!rb || !prev_rb) begin
            async_q.push_back(snap({tag, " async"}));
            ->async_ev;
        end
        prev_rb = rb;
        if (!rb) begin
            m_q1 = 1'b0;
            m_q8 = 8'h00;
        end else if (!sb) begin
            m_q1    = 1'b1;
            m_q8    = 8'hFF;
            m_valid = 1'b1;
        end else if (ld) begin
            m_q1 = d1;
            m_q8 = d8;
        end
        edge_q.push_back(snap(tag));
    endtask

    initial begin
        RB = 1'b1;
        SB = 1'b1;
        LD = 1'b0;
        D1 = 1'b0;
        D8 = 8'h00;
        // Edge at t=50: Q still unknown, nothing to check.
        edge_q.push_back(snap("pre"));

        // Set, then release set and hold.
        step("set",          1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        step("set hold",     1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        // Mid-cycle asynchronous reset, then release without a qualifying edge.
        step("reset",        1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        step("reset rel",    1'b1, 1'b1, 1'b0, 1'b1, 8'hA5);
        // Load, then hold across two edges.
        step("load",         1'b1, 1'b1, 1'b1, 1'b1, 8'h5A);
        step("load hold1",   1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        step("load hold2",   1'b1, 1'b1, 1'b0, 1'b0, 8'hFF);
        // Priorities.
        step("set over ld",  1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        step("rb over sb",   1'b0, 1'b0, 1'b1, 1'b1, 8'h3C);
        step("load again",   1'b1, 1'b1, 1'b1, 1'b1, 8'hC3);

        // RB falls exactly on a rising edge while a load of ones is pending.
        @(negedge CK);
        #25;
        SB = 1'b1;
        LD = 1'b1;
        D1 = 1'b1;
        D8 = 8'h77;
        m_q1 = 1'b0;
        m_q8 = 8'h00;
        edge_q.push_back(snap("rb at edge"));
        @(posedge CK);
        RB = 1'b0;
        prev_rb = 1'b0;

        step("reset rel2",   1'b1, 1'b1, 1'b1, 1'b1, 8'h96);

        // Hold with D toggling every half cycle for four cycles.
        for (int i = 0; i < 4; i++) begin
            step("hold toggle", 1'b1, 1'b1, 1'b0, ~D1, ~D8);
            #50;
            D1 = ~D1;
            D8 = ~D8;
        end

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            step("random",
                 logic'($urandom_range(0, 9) != 0),
                 logic'($urandom_range(0, 3) != 0),
                 logic'($urandom_range(0, 1)),
                 logic'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)));
        end

        @(posedge CK);
        #2;
        if (edge_q.size() != 0 || async_q.size() != 0) begin
            chk("queues drained", 8'(edge_q.size() + async_q.size()), 8'd0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_dff_sync
